rsp_framer: RTL and testbench
=============================

// Module: rsp_framer
// PURPOSE
// - Downstream of the system/command units: collects param_data words strobed by
//   param_write, takes the response code presented on cmd_done, and serializes one
//   framed response onto the byte-wide host TX stream.
// - Also arbitrates unsolicited (involuntary) messages, e.g. shutdown reports,
//   against the command path via invol_req/invol_grant.
// PARAMETERS
// - MAX_PARAMS  8      param words buffered per response (power of 2, >=1)
// - RSP_BITS    8      response-code width; only the low 8 bits are framed
// - SYNC_BYTE   8'h7E  frame start marker
// PORTS
// - clk          in   1         system clock
// - rst_n        in   1         reset, asynchronous, active-low
// - param_data   in   32        param word, or the response code while cmd_done=1
// - param_write  in   1         param_data is a param word this cycle
// - cmd_done     in   1         1-cycle pulse; param_data[RSP_BITS-1:0] = code
// - cmd_active   in   1         decoder has dispatched a command not yet done
// - invol_req    in   1         unit requests an unsolicited response slot
// - invol_grant  out  1         1-cycle grant pulse
// - rsp_busy     out  1         blocks decoder dispatch while framing/invol owns bus
// - tx_data      out  8         byte to host transport
// - tx_valid     out  1         tx_data valid
// - tx_ready     in   1         transport accepts byte (transfer = valid&ready)
// - param_ovf    out  1         sticky: a param word was dropped; cleared by reset only
// BEHAVIOUR
// - Reset values: all outputs 0, FIFO empty, checksum 0, state S_COLLECT.
// - S_COLLECT: each cycle with param_write=1, param_data is pushed. When FIFO holds
//   MAX_PARAMS, the write is dropped and param_ovf set. param_write with cmd_done in
//   the same cycle: the word is pushed and cmd_done still ends the collection.
// - cmd_done in S_COLLECT: latch code and word count n, assert rsp_busy next cycle,
//   go to S_SYNC. cmd_done in any other state is ignored; the unit must not issue it.
// - Frame byte order: SYNC_BYTE, LEN=4*n, CODE, then params in push order, each
//   little-endian (bits 7:0 first), then CSUM = XOR of LEN, CODE and all param bytes.
//   SYNC_BYTE is excluded from CSUM.
// - States: S_SYNC -> S_LEN -> S_CODE -> S_PARAM (byte idx 0..3, word idx 0..n-1;
//   skipped when n=0) -> S_CSUM -> S_COLLECT. Advance only on tx_valid&tx_ready.
//   tx_data stays stable while tx_valid=1 and tx_ready=0.
// - tx_valid is registered: it is first asserted 1 cycle after cmd_done. At most one
//   byte per cycle. With tx_ready held 1, a frame takes 4*n+4 cycles.
// - On the cycle after the CSUM transfer: rsp_busy=0, FIFO empty, checksum cleared.
// - param_write outside S_COLLECT: the word is dropped and param_ovf set.
// - Invol arbitration: grant only when state=S_COLLECT, FIFO empty, cmd_active=0,
//   rsp_busy=0 and invol_req=1. invol_grant is a 1-cycle pulse. From the grant cycle
//   until the following cmd_done, an internal invol_own flag holds rsp_busy=1; the
//   unit's params collect and frame normally.
// - Command wins ties: if cmd_active=1 in the same cycle as invol_req, no grant is
//   issued; invol_req stays pending until the command's frame completes.
// - Reset mid-frame: state, FIFO, byte counters, invol_own and tx_valid clear
//   immediately. No partial-frame recovery; the host resyncs on SYNC_BYTE.
// - Widths: LEN is 8 bits, so MAX_PARAMS<=63. Word count uses $clog2(MAX_PARAMS)+1 bits.
// STRUCTURE
// - Shared package: frame field constants (SYNC_BYTE default, header length 3,
//   trailer length 1) and framer state encoding, so the host-side RX parser and the
//   TB scoreboard use the same values.
// - Sub-module param_fifo: single-clock, MAX_PARAMS x 32, with push, pop, count,
//   full and empty, and flush on frame end. The framer FSM, byte mux and XOR
//   checksum stay in rsp_framer.
// TESTING
// - GET_VERSION-like: 3 writes 0x01020304, 0x05060708, 0x0009000A, then
//   cmd_done code 0x11, tx_ready=1
//   -> 7E 0C 11 04 03 02 01 08 07 06 05 0A 00 09 00 CSUM, 16 bytes over 16
//   cycles, rsp_busy high throughout.
// - Zero-param response: cmd_done code 0x05 only -> 7E 00 05 05.
// - Backpressure: toggle tx_ready randomly during frame 1 -> identical bytes;
//   tx_data is stable whenever tx_valid=1 and tx_ready=0.
// - Overflow: MAX_PARAMS+2 writes, then cmd_done -> LEN=4*MAX_PARAMS, first
//   MAX_PARAMS words sent, param_ovf=1.
// - Invol vs command: invol_req with cmd_active=1 -> no grant until that command's
//   frame ends. Then a grant pulse follows, then 2 params plus code 0x20 frame
//   correctly.
// - Reset: rst_n low mid-S_PARAM -> tx_valid, rsp_busy and invol_grant drop
//   asynchronously. The next command frames from SYNC_BYTE with a correct CSUM.

Source files
------------

// File: rtl/rsp_framer_pkg.sv
// Shared frame-field constants and framer state encoding, used by the framer,
// the host-side RX parser and the bench scoreboard.
package rsp_framer_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;
  localparam int         HDR_LEN      = 3;  // SYNC, LEN, CODE
  localparam int         TRL_LEN      = 1;  // CSUM

  typedef enum logic [2:0] {
    S_COLLECT,
    S_SYNC,
    S_LEN,
    S_CODE,
    S_PARAM,
    S_CSUM
  } framer_state_e;

  // Total bytes on the wire for a response carrying n param words.
  function automatic int frame_len(input int n);
    return HDR_LEN + 4 * n + TRL_LEN;
  endfunction

endpackage

// File: rtl/rsp_framer_if.sv
// Byte-wide host TX stream: valid/ready handshake, transfer on valid & ready.
interface rsp_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/rsp_framer_param_fifo.sv
// Single-clock param word FIFO; flush empties it at frame end.
module rsp_framer_param_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !full) wr_ptr <= ptr_inc(wr_ptr);
      if (pop && !empty) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push && !full) - CW'(pop && !empty);
    end
  end

endmodule

// File: rtl/rsp_framer.sv
// Response framer: buffers param words, then serializes SYNC/LEN/CODE/params/CSUM
// onto the byte stream; also grants unsolicited response slots.
module rsp_framer
  import rsp_framer_pkg::*;
#(
  parameter int         MAX_PARAMS = 8,
  parameter int         RSP_BITS   = 8,
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   param_data,
  input  logic          param_write,
  input  logic          cmd_done,
  input  logic          cmd_active,
  input  logic          invol_req,
  output logic          invol_grant,
  output logic          rsp_busy,
  output logic          param_ovf,
  rsp_framer_if.master  tx
);
  localparam int CW = $clog2(MAX_PARAMS) + 1;
  localparam int CB = (RSP_BITS < 8) ? RSP_BITS : 8;

  framer_state_e state, nxt;
  logic [CW-1:0] fifo_cnt, n_q, wrd_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    code_q, csum_q, len_b;
  logic [31:0]   head;
  logic          fifo_full, fifo_empty, push, pop, flush, xfer, done_ok;
  logic          invol_own, grant_ok;

  assign xfer    = tx.tx_valid && tx.tx_ready;
  assign done_ok = (state == S_COLLECT) && cmd_done;
  assign push    = param_write && (state == S_COLLECT) && !fifo_full;
  assign pop     = xfer && (state == S_PARAM) && (byte_idx == 2'd3);
  assign flush   = xfer && (state == S_CSUM);
  assign len_b   = 8'(n_q) << 2;

  rsp_framer_param_fifo #(.DEPTH(MAX_PARAMS), .W(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (param_data),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_COLLECT: if (cmd_done) nxt = S_SYNC;
      S_SYNC:    if (xfer) nxt = S_LEN;
      S_LEN:     if (xfer) nxt = S_CODE;
      S_CODE:    if (xfer) nxt = (n_q == '0) ? S_CSUM : S_PARAM;
      S_PARAM:   if (pop && (wrd_idx == n_q - CW'(1))) nxt = S_CSUM;
      S_CSUM:    if (xfer) nxt = S_COLLECT;
      default:   nxt = S_COLLECT;
    endcase
  end

  always_comb begin
    tx.tx_data = 8'h00;
    unique case (state)
      S_SYNC:  tx.tx_data = SYNC_BYTE;
      S_LEN:   tx.tx_data = len_b;
      S_CODE:  tx.tx_data = code_q;
      S_PARAM: tx.tx_data = head[8*byte_idx +: 8];
      S_CSUM:  tx.tx_data = csum_q;
      default: tx.tx_data = 8'h00;
    endcase
  end

  // rsp_busy comes straight from registers, so the grant check has no comb loop.
  assign rsp_busy = (state != S_COLLECT) || invol_own;
  assign grant_ok = (state == S_COLLECT) && fifo_empty && !cmd_active && !rsp_busy
                    && invol_req && !cmd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_COLLECT;
      tx.tx_valid <= 1'b0;
      n_q         <= '0;
      code_q      <= '0;
      byte_idx    <= '0;
      wrd_idx     <= '0;
      csum_q      <= '0;
      param_ovf   <= 1'b0;
      invol_grant <= 1'b0;
      invol_own   <= 1'b0;
    end else begin
      state       <= nxt;
      tx.tx_valid <= (nxt != S_COLLECT);
      invol_grant <= grant_ok;
      if (param_write && !push) param_ovf <= 1'b1;
      if (grant_ok)     invol_own <= 1'b1;
      else if (done_ok) invol_own <= 1'b0;
      if (done_ok) begin
        // A write alongside cmd_done belongs to this response.
        n_q      <= fifo_cnt + CW'(push);
        code_q   <= 8'(param_data[CB-1:0]);
        byte_idx <= '0;
        wrd_idx  <= '0;
      end
      if (xfer && (state == S_PARAM)) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) wrd_idx <= wrd_idx + CW'(1);
      end
      if (xfer && (state inside {S_LEN, S_CODE, S_PARAM})) csum_q <= csum_q ^ tx.tx_data;
      else if (flush) csum_q <= '0;
    end
  end

endmodule

// File: tb/tb_rsp_framer.sv
// Scoreboard bench for rsp_framer: stimulus pushes expected bytes, a negedge
// monitor pops and compares every transferred byte.
module tb_rsp_framer;
  import rsp_framer_pkg::*;

  localparam int MAXP = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] param_data = '0;
  logic        param_write = 1'b0, cmd_done = 1'b0, cmd_active = 1'b0, invol_req = 1'b0;
  logic        invol_grant, rsp_busy, param_ovf;
  logic        bp_en = 1'b0;

  rsp_framer_if tx_if();

  rsp_framer #(.MAX_PARAMS(MAXP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .param_data  (param_data),
    .param_write (param_write),
    .cmd_done    (cmd_done),
    .cmd_active  (cmd_active),
    .invol_req   (invol_req),
    .invol_grant (invol_grant),
    .rsp_busy    (rsp_busy),
    .param_ovf   (param_ovf),
    .tx          (tx_if)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  int          bytes_rx = 0, vld_cyc = 0, grant_cnt = 0;
  logic [7:0]  sb_q[$];
  logic [31:0] words_q[$];
  logic        mon_stall = 1'b0;
  logic [7:0]  mon_hold = '0, mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transport: always ready, or random ready while backpressure is enabled.
  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_if.tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: byte compare, stall stability, busy-while-valid, grant counting.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_if.tx_valid) begin
        vld_cyc++;
        chk("busy_during_tx", 32'(rsp_busy), 32'd1);
      end
      if (mon_stall && tx_if.tx_valid) chk("stall_stable", 32'(tx_if.tx_data), 32'(mon_hold));
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte: got %0h expected no byte", tx_if.tx_data);
        end else begin
          mon_exp = sb_q.pop_front();
          chk("tx_byte", 32'(tx_if.tx_data), 32'(mon_exp));
        end
        bytes_rx++;
      end
      mon_stall = tx_if.tx_valid && !tx_if.tx_ready;
      mon_hold  = tx_if.tx_data;
      if (invol_grant) grant_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic pw, input logic [31:0] pd, input logic cd);
    @(posedge clk); #1;
    param_write = pw; param_data = pd; cmd_done = cd;
    if (cd) cmd_active = 1'b0;
  endtask

  task automatic write_words();
    foreach (words_q[i]) drive(1'b1, words_q[i], 1'b0);
  endtask

  task automatic do_done(input logic [7:0] code);
    drive(1'b0, {24'h0, code}, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
  endtask

  // Reference frame for the words in words_q (first MAXP kept).
  task automatic push_frame(input logic [7:0] code);
    int n;
    logic [7:0] cs, b;
    n = (words_q.size() > MAXP) ? MAXP : words_q.size();
    cs = 8'(4 * n) ^ code;
    sb_q.push_back(SYNC_DEFAULT);
    sb_q.push_back(8'(4 * n));
    sb_q.push_back(code);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) begin
        b = 8'(words_q[w] >> (8 * k));
        sb_q.push_back(b);
        cs ^= b;
      end
    sb_q.push_back(cs);
  endtask

  task automatic send_cmd(input logic [7:0] code);
    push_frame(code);
    write_words();
    do_done(code);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || rsp_busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk({name, "_done_in_time"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[i]) sb_q.push_back(b[i]);
  endtask

  initial begin
    logic [7:0] gv[], zp[], iv[];
    int n;
    gv = '{8'h7E, 8'h0C, 8'h11, 8'h04, 8'h03, 8'h02, 8'h01, 8'h08,
           8'h07, 8'h06, 8'h05, 8'h0A, 8'h00, 8'h09, 8'h00, 8'h16};
    zp = '{8'h7E, 8'h00, 8'h05, 8'h05};
    iv = '{8'h7E, 8'h08, 8'h20, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h2B};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    chk("rst_busy", 32'(rsp_busy), 32'd0);
    chk("rst_grant", 32'(invol_grant), 32'd0);
    chk("rst_ovf", 32'(param_ovf), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // GET_VERSION-like frame, hand-computed bytes, full-rate transport
    words_q = '{32'h01020304, 32'h05060708, 32'h0009000A};
    push_bytes(gv);
    vld_cyc = 0; bytes_rx = 0;
    write_words();
    drive(1'b0, 32'h11, 1'b1);
    chk("gv_valid_at_done", 32'(tx_if.tx_valid), 32'd0);
    chk("gv_busy_at_done", 32'(rsp_busy), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    chk("gv_valid_latency", 32'(tx_if.tx_valid), 32'd1);
    chk("gv_busy_after_done", 32'(rsp_busy), 32'd1);
    wait_done("gv");
    chk("gv_valid_cycles", 32'(vld_cyc), 32'd16);
    chk("gv_bytes", 32'(bytes_rx), 32'(frame_len(3)));
    chk("gv_busy_end", 32'(rsp_busy), 32'd0);

    // Zero-param response
    words_q.delete();
    push_bytes(zp);
    bytes_rx = 0;
    do_done(8'h05);
    wait_done("zp");
    chk("zp_bytes", 32'(bytes_rx), 32'd4);

    // Backpressure: same frame with random tx_ready
    words_q = '{32'h01020304, 32'h05060708, 32'h0009000A};
    push_bytes(gv);
    bp_en = 1'b1;
    write_words();
    do_done(8'h11);
    wait_done("bp");
    bp_en = 1'b0;

    // Invol vs command: command wins, grant follows its frame
    @(posedge clk); #1;
    cmd_active = 1'b1; invol_req = 1'b1; grant_cnt = 0;
    repeat (3) @(posedge clk);
    words_q = '{32'hDEADBEEF};
    send_cmd(8'h40);
    wait_done("cmd_vs_invol");
    chk("no_grant_during_cmd", 32'(grant_cnt), 32'd0);
    n = 0;
    while (!invol_grant && n < 20) begin @(negedge clk); n++; end
    chk("grant_seen", 32'(invol_grant), 32'd1);
    chk("grant_busy", 32'(rsp_busy), 32'd1);
    invol_req = 1'b0;
    @(negedge clk);
    chk("grant_pulse", 32'(invol_grant), 32'd0);
    chk("invol_own_busy", 32'(rsp_busy), 32'd1);
    words_q = '{32'h00000001, 32'h00000002};
    push_bytes(iv);
    write_words();
    do_done(8'h20);
    wait_done("invol");
    chk("grant_count", 32'(grant_cnt), 32'd1);
    chk("invol_busy_end", 32'(rsp_busy), 32'd0);

    // Overflow: MAXP+2 writes, only MAXP framed
    chk("ovf_clear_before", 32'(param_ovf), 32'd0);
    words_q.delete();
    for (int i = 0; i < MAXP + 2; i++) words_q.push_back(32'h0A0B0000 + 32'(i));
    bytes_rx = 0;
    send_cmd(8'h33);
    wait_done("ovf");
    chk("ovf_flag", 32'(param_ovf), 32'd1);
    chk("ovf_bytes", 32'(bytes_rx), 32'(frame_len(MAXP)));

    // Reset mid-S_PARAM, then a clean frame
    words_q = '{32'hAABBCCDD, 32'h11223344};
    bytes_rx = 0;
    send_cmd(8'h77);
    n = 0;
    while (bytes_rx < 5 && n < 100) begin @(negedge clk); n++; end
    chk("rst_reach_param", 32'(bytes_rx >= 5), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("midrst_busy", 32'(rsp_busy), 32'd0);
    chk("midrst_grant", 32'(invol_grant), 32'd0);
    chk("midrst_ovf", 32'(param_ovf), 32'd0);
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    words_q = '{32'hCAFEF00D};
    bytes_rx = 0;
    send_cmd(8'h99);
    wait_done("post_rst");
    chk("post_rst_bytes", 32'(bytes_rx), 32'(frame_len(1)));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
